spi_target: RTL and testbench

SPI_TARGET -- requirements
Module: spi_target

---
 rtl/spi_target_pkg.sv | 17 +
 rtl/spi_target_byte_fifo.sv | 47 ++++
 rtl/spi_target_defs.vh | 23 ++
 rtl/spi_target.sv | 187 ++++++++++++++++++
 tb/tb_spi_target.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_target_pkg.sv
// Shared types for the SPI target: shift-engine state and TX byte selection.
// No logic of its own; latency and backpressure belong to the users.
package spi_target_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [7:0] TX_UNDERRUN_BYTE = 8'hFF;

   // Next byte for the TX shifter: FIFO head, or all-ones when starved.
   function automatic logic [7:0] tx_next(input logic empty, input logic [7:0] head);
      return empty ? TX_UNDERRUN_BYTE : head;
   endfunction

endpackage

// File: rtl/spi_target_byte_fifo.sv
// Byte FIFO, power-of-two depth, head visible combinationally on pop_dat.
// Push/pop take effect on the clk edge; push to full is dropped unless a pop frees the slot.
module byte_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_dat,
   input  logic          pop,
   output logic [7:0]    pop_dat,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/spi_target_defs.vh
// Register offsets and STATUS/INTSTAT bit positions shared by the SPI target RTL.
`ifndef SPI_TARGET_DEFS_VH
`define SPI_TARGET_DEFS_VH

`define SPI_REG_DATA     2'd0
`define SPI_REG_STATUS   2'd1
`define SPI_REG_CTRL     2'd2
`define SPI_REG_INTSTAT  2'd3

`define SPI_ST_RXCNT     0
`define SPI_ST_TXCNT     8
`define SPI_ST_RXNE      16
`define SPI_ST_TXFULL    17
`define SPI_ST_OVR       18
`define SPI_ST_UDR       19
`define SPI_ST_SSACT     20

`define SPI_INT_RXNE     0
`define SPI_INT_TXE      1
`define SPI_INT_OVR      2
`define SPI_INT_SSR      3

`endif

// File: rtl/spi_target.sv
// SPI target (mode 3 or 0) with RX/TX byte FIFOs and a 4-register CPU port.
// MISO leads by one clk after SS sync; full RX drops bytes (overrun), empty TX sends 0xFF (underrun).
`include "spi_target_defs.vh"

module spi_target
   import spi_target_pkg::*;
#(
   parameter int POLARITY   = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  we,
   input  logic        rd,
   input  logic        select,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        interrupt,
   input  logic        spi_ss_n,
   input  logic        spi_sck,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe
);

   localparam int   CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic SCK_IDLE = (POLARITY != 0);

   logic [1:0]    ss_sync, sck_sync, mosi_sync;
   logic          ss_prev, sck_prev;
   logic          ss_q, sck_q, mosi_q;
   logic          ss_fall, ss_rise, sck_rise, sck_fall;
   state_t        state, state_nxt;
   logic          frame_start, frame_end, bit_shift, byte_done, tx_load, tx_advance;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift, tx_shift, rx_byte;
   logic          overrun, underrun, ovr_evt, ssr_evt;
   logic [3:0]    ctrl, intstat, int_clr;
   logic          cpu_wr, cpu_rd, rx_pop, rx_drop, tx_push, tx_pop;
   logic [7:0]    rx_head, tx_head;
   logic [CW-1:0] rx_count, tx_count;
   logic          rx_full, rx_empty, tx_full, tx_empty;
   logic          unused_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_sync   <= 2'b11;
         sck_sync  <= {2{SCK_IDLE}};
         mosi_sync <= 2'b00;
         ss_prev   <= 1'b1;
         sck_prev  <= SCK_IDLE;
      end else begin
         ss_sync   <= {ss_sync[0], spi_ss_n};
         sck_sync  <= {sck_sync[0], spi_sck};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         ss_prev   <= ss_q;
         sck_prev  <= sck_q;
      end
   end

   assign ss_q     = ss_sync[1];
   assign sck_q    = sck_sync[1];
   assign mosi_q   = mosi_sync[1];
   assign ss_fall  = ss_prev & ~ss_q;
   assign ss_rise  = ~ss_prev & ss_q;
   assign sck_rise = ~sck_prev & sck_q;
   assign sck_fall = sck_prev & ~sck_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (ss_fall) state_nxt = ST_ACTIVE;
         ST_ACTIVE: if (ss_rise) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // The first falling edge of each byte leaves the preloaded MSB in place.
   always_comb begin
      frame_start = 1'b0;
      frame_end   = 1'b0;
      bit_shift   = 1'b0;
      byte_done   = 1'b0;
      tx_advance  = 1'b0;
      case (state)
         ST_IDLE: frame_start = ss_fall;
         ST_ACTIVE: begin
            if (ss_rise) begin
               frame_end = 1'b1;
            end else begin
               bit_shift  = sck_rise;
               byte_done  = sck_rise && (bit_cnt == 3'd7);
               tx_advance = sck_fall && (bit_cnt != 3'd0);
            end
         end
         default: ;
      endcase
      tx_load = frame_start | byte_done;
   end

   assign rx_byte = {rx_shift[6:0], mosi_q};
   assign cpu_wr  = select & (|we);
   assign cpu_rd  = select & rd;
   assign tx_push = cpu_wr && (addr == `SPI_REG_DATA);
   assign tx_pop  = tx_load & ~tx_empty;
   assign rx_pop  = cpu_rd && (addr == `SPI_REG_DATA) && !rx_empty;
   assign rx_drop = byte_done & rx_full & ~rx_pop;
   assign int_clr = (cpu_wr && (addr == `SPI_REG_INTSTAT)) ? wdata[3:0] : 4'b0000;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
         ovr_evt  <= 1'b0;
         ssr_evt  <= 1'b0;
         ctrl     <= '0;
      end else begin
         if (frame_start || frame_end) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
         end else if (bit_shift) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= rx_byte;
         end
         if (tx_load)         tx_shift <= tx_next(tx_empty, tx_head);
         else if (tx_advance) tx_shift <= {tx_shift[6:0], 1'b1};
         if (tx_load && tx_empty)        underrun <= 1'b1;
         else if (int_clr[`SPI_INT_SSR]) underrun <= 1'b0;
         if (rx_drop)                    overrun <= 1'b1;
         else if (int_clr[`SPI_INT_OVR]) overrun <= 1'b0;
         if (rx_drop)                    ovr_evt <= 1'b1;
         else if (int_clr[`SPI_INT_OVR]) ovr_evt <= 1'b0;
         if (frame_end)                  ssr_evt <= 1'b1;
         else if (int_clr[`SPI_INT_SSR]) ssr_evt <= 1'b0;
         if (cpu_wr && (addr == `SPI_REG_CTRL)) ctrl <= wdata[3:0];
      end
   end

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(byte_done), .push_dat(rx_byte), .pop(rx_pop),
      .pop_dat(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .push_dat(wdata[7:0]), .pop(tx_pop),
      .pop_dat(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
   );

   assign intstat[`SPI_INT_RXNE] = ~rx_empty;
   assign intstat[`SPI_INT_TXE]  = tx_empty;
   assign intstat[`SPI_INT_OVR]  = ovr_evt;
   assign intstat[`SPI_INT_SSR]  = ssr_evt;
   assign interrupt   = |(intstat & ctrl);
   assign spi_miso    = (state == ST_ACTIVE) ? tx_shift[7] : 1'b1;
   assign spi_miso_oe = (state == ST_ACTIVE) & ~ss_q;
   assign unused_wdata = ^wdata[31:8];

   always_comb begin
      rdata = '0;
      if (cpu_rd) begin
         case (addr)
            `SPI_REG_DATA: rdata[7:0] = rx_empty ? 8'h00 : rx_head;
            `SPI_REG_STATUS: begin
               rdata[`SPI_ST_RXCNT +: 5] = 5'(rx_count);
               rdata[`SPI_ST_TXCNT +: 5] = 5'(tx_count);
               rdata[`SPI_ST_RXNE]       = ~rx_empty;
               rdata[`SPI_ST_TXFULL]     = tx_full;
               rdata[`SPI_ST_OVR]        = overrun;
               rdata[`SPI_ST_UDR]        = underrun;
               rdata[`SPI_ST_SSACT]      = (state == ST_ACTIVE);
            end
            `SPI_REG_CTRL: rdata[3:0] = ctrl;
            default:       rdata[3:0] = intstat;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target (mode 3, depth 8): expected CPU reads and MISO bytes
// are queued by the stimulus and consumed by independent monitors.
module tb_spi_target;

   localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_INT = 2'd3;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  we = 4'h0;
   logic        rd = 1'b0;
   logic        select = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        interrupt;
   logic        spi_ss_n = 1'b1;
   logic        spi_sck = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_miso_oe;

   int          n_checks = 0;
   int          n_fail = 0;
   rd_exp_t     exp_rd_q[$];
   logic [7:0]  exp_miso_q[$];

   spi_target #(.POLARITY(1), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .we(we), .rd(rd), .select(select), .addr(addr),
      .wdata(wdata), .rdata(rdata), .interrupt(interrupt), .spi_ss_n(spi_ss_n),
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cpu_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      rd_exp_t e;
      e.name = name;
      e.exp  = exp;
      @(posedge clk); #1;
      select = 1'b1; rd = 1'b1; addr = a;
      exp_rd_q.push_back(e);
      @(posedge clk); #1;
      select = 1'b0; rd = 1'b0;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      select = 1'b1; we = 4'hF; addr = a; wdata = d;
      @(posedge clk); #1;
      select = 1'b0; we = 4'h0; wdata = 32'h0;
   endtask

   task automatic ss_low();
      @(negedge clk);
      spi_ss_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic ss_high();
      repeat (2) @(negedge clk);
      spi_ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Mode 3 host at clk/8; optionally lands a DATA read on the clk the 8th bit is pushed.
   task automatic host_byte(input logic [7:0] mo, input logic [7:0] mi_exp, input int nbits,
                            input bit rd_last, input logic [7:0] rd_exp);
      rd_exp_t e;
      if (nbits == 8) exp_miso_q.push_back(mi_exp);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         spi_sck  = 1'b0;
         spi_mosi = mo[7-i];
         repeat (4) @(negedge clk);
         spi_sck = 1'b1;
         if (rd_last && (i == nbits - 1)) begin
            @(posedge clk);
            @(posedge clk); #1;
            select = 1'b1; rd = 1'b1; addr = A_DATA;
            e.name = "data_coincident";
            e.exp  = {24'h0, rd_exp};
            exp_rd_q.push_back(e);
            @(posedge clk); #1;
            select = 1'b0; rd = 1'b0;
         end
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin : rd_monitor
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (select && rd) begin
            if (exp_rd_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rd_unexpected: got 0x%08h, no read expected", rdata);
            end else begin
               e = exp_rd_q.pop_front();
               check(e.name, rdata, e.exp);
            end
         end
      end
   end

   initial begin : miso_monitor
      logic [7:0] sh;
      int         nb;
      sh = 8'h00;
      nb = 0;
      forever begin
         @(posedge spi_sck or posedge spi_ss_n or posedge reset);
         if (reset || spi_ss_n) begin
            nb = 0;
         end else begin
            sh = {sh[6:0], spi_miso};
            nb++;
            if (nb == 8) begin
               nb = 0;
               if (exp_miso_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL miso_unexpected: got 0x%02h, no byte expected", sh);
               end else begin
                  check("miso_byte", {24'h0, sh}, {24'h0, exp_miso_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500us;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_interrupt", {31'h0, interrupt}, 32'h0);
      check("rst_miso", {31'h0, spi_miso}, 32'h1);
      check("rst_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cpu_read(A_STATUS, 32'h0000_0000, "status_after_reset");
      cpu_read(A_INT, 32'h0000_0002, "intstat_after_reset");

      // Two-byte exchange with preloaded TX
      cpu_write(A_DATA, 32'h0000_00A5);
      cpu_write(A_DATA, 32'h0000_003C);
      cpu_read(A_STATUS, 32'h0000_0200, "status_tx2");
      ss_low();
      host_byte(8'h12, 8'hA5, 8, 1'b0, 8'h00);
      host_byte(8'h34, 8'h3C, 8, 1'b0, 8'h00);
      ss_high();
      cpu_read(A_STATUS, 32'h0009_0002, "status_rx2");
      cpu_read(A_DATA, 32'h0000_0012, "data_0x12");
      cpu_read(A_DATA, 32'h0000_0034, "data_0x34");
      cpu_read(A_STATUS, 32'h0008_0000, "status_rx0");
      cpu_read(A_INT, 32'h0000_000A, "intstat_txe_ssr");
      cpu_write(A_INT, 32'h0000_000F);
      cpu_read(A_STATUS, 32'h0000_0000, "status_cleared");

      // Empty TX underrun
      ss_low();
      host_byte(8'h55, 8'hFF, 8, 1'b0, 8'h00);
      ss_high();
      cpu_read(A_STATUS, 32'h0009_0001, "status_underrun");
      cpu_write(A_INT, 32'h0000_0008);
      cpu_read(A_STATUS, 32'h0001_0001, "status_underrun_clr");
      cpu_write(A_CTRL, 32'h0000_0001);
      check("irq_rxne_on", {31'h0, interrupt}, 32'h1);
      cpu_read(A_DATA, 32'h0000_0055, "data_0x55");
      check("irq_rxne_off", {31'h0, interrupt}, 32'h0);

      // Aborted partial byte, then a clean 0x7E
      cpu_write(A_CTRL, 32'h0000_0008);
      ss_low();
      host_byte(8'hAA, 8'h00, 5, 1'b0, 8'h00);
      ss_high();
      check("irq_ss_rise", {31'h0, interrupt}, 32'h1);
      cpu_write(A_INT, 32'h0000_0008);
      check("irq_ss_rise_clr", {31'h0, interrupt}, 32'h0);
      ss_low();
      host_byte(8'h7E, 8'hFF, 8, 1'b0, 8'h00);
      ss_high();
      cpu_read(A_STATUS, 32'h0009_0001, "status_after_abort");
      cpu_read(A_DATA, 32'h0000_007E, "data_0x7e");
      cpu_read(A_DATA, 32'h0000_0000, "data_empty");
      cpu_write(A_INT, 32'h0000_000F);
      cpu_write(A_CTRL, 32'h0000_0000);

      // Nine bytes into a depth-8 RX FIFO
      ss_low();
      for (int i = 0; i < 9; i++) host_byte(8'h81 + 8'(i), 8'hFF, 8, 1'b0, 8'h00);
      ss_high();
      cpu_read(A_STATUS, 32'h000D_0008, "status_overrun");
      cpu_read(A_INT, 32'h0000_000F, "intstat_all");
      cpu_write(A_INT, 32'h0000_000C);
      cpu_read(A_STATUS, 32'h0001_0008, "status_ovr_clr");

      // Read coinciding with a push while full
      ss_low();
      host_byte(8'h5A, 8'hFF, 8, 1'b1, 8'h81);
      ss_high();
      cpu_read(A_STATUS, 32'h0009_0008, "status_full_pushpop");
      for (int i = 1; i < 8; i++) cpu_read(A_DATA, 32'h81 + 32'(i), "data_fill");
      cpu_read(A_DATA, 32'h0000_005A, "data_0x5a");
      cpu_read(A_STATUS, 32'h0008_0000, "status_drained");
      cpu_write(A_INT, 32'h0000_000F);

      // Asynchronous reset mid-byte
      cpu_write(A_DATA, 32'h0000_0099);
      cpu_write(A_CTRL, 32'h0000_0002);
      ss_low();
      host_byte(8'h00, 8'h00, 3, 1'b0, 8'h00);
      check("pre_rst_irq", {31'h0, interrupt}, 32'h1);
      check("pre_rst_oe", {31'h0, spi_miso_oe}, 32'h1);
      check("pre_rst_miso", {31'h0, spi_miso}, 32'h0);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      check("arst_rdata", rdata, 32'h0);
      check("arst_irq", {31'h0, interrupt}, 32'h0);
      check("arst_miso", {31'h0, spi_miso}, 32'h1);
      check("arst_oe", {31'h0, spi_miso_oe}, 32'h0);
      spi_ss_n = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      cpu_read(A_STATUS, 32'h0000_0000, "status_post_reset");
      cpu_read(A_CTRL, 32'h0000_0000, "ctrl_post_reset");
      cpu_write(A_DATA, 32'h0000_00C3);
      ss_low();
      host_byte(8'h3D, 8'hC3, 8, 1'b0, 8'h00);
      ss_high();
      cpu_read(A_DATA, 32'h0000_003D, "data_0x3d");
      cpu_read(A_STATUS, 32'h0008_0000, "status_final");

      repeat (10) @(negedge clk);
      check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
      check("miso_queue_drained", 32'(exp_miso_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
